// File: rtl/dcache_wb_param_if.sv
// CPU load/store port and block memory port of the parametrised write-back data cache.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface dcache_wb_param_if #(
  parameter int ADDR_W      = 8,
  parameter int BLOCK_BYTES = 4
);
  localparam int OFFSET_W = $clog2(BLOCK_BYTES);

  logic                        read;
  logic                        write;
  logic [ADDR_W-1:0]           address;
  logic [7:0]                  writedata;
  logic [7:0]                  readdata;
  logic                        busywait;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-OFFSET_W-1:0]  mem_address;
  logic [8*BLOCK_BYTES-1:0]    mem_writedata;
  logic [8*BLOCK_BYTES-1:0]    mem_readdata;
  logic                        mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_wb_param.sv
// Direct-mapped, write-back, write-allocate byte cache with a block-wide memory port.
// Optional macro DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module dcache_wb_param #(
  parameter int ADDR_W      = 8,
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  dcache_wb_param_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       writeback_count
`endif
);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH} state_t;

  state_t               r_state, w_state_next;
  logic [BLOCK_W-1:0]   r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [7:0]           r_readdata;

  logic [TAG_W-1:0]     w_tag;
  logic [INDEX_W-1:0]   w_index;
  logic [OFFSET_W-1:0]  w_offset;
  logic [7:0]           w_rd_byte;
  logic                 w_req, w_hit;
  logic                 w_read_hit, w_write_hit, w_wb_done, w_fill;

  assign w_tag     = bus.address[ADDR_W-1 -: TAG_W];
  assign w_index   = bus.address[OFFSET_W +: INDEX_W];
  assign w_offset  = bus.address[OFFSET_W-1:0];
  assign w_req     = bus.read | bus.write;
  assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_rd_byte = r_data[w_index][{w_offset, 3'b000} +: 8];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    w_state_next      = r_state;
    w_read_hit        = 1'b0;
    w_write_hit       = 1'b0;
    w_wb_done         = 1'b0;
    w_fill            = 1'b0;
    bus.busywait      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_write_hit = bus.write;
            w_read_hit  = ~bus.write;
          end else begin
            bus.busywait = 1'b1;
            w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {r_tag[w_index], w_index};
        bus.mem_writedata = r_data[w_index];
        bus.busywait      = 1'b1;
        if (!bus.mem_busywait) begin
          w_wb_done    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {w_tag, w_index};
        bus.busywait    = 1'b1;
        if (!bus.mem_busywait) begin
          w_fill       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    bus.readdata = w_read_hit ? w_rd_byte : r_readdata;

    // Reset silences the memory request in the same cycle it is asserted.
    if (reset) begin
      w_state_next      = S_IDLE;
      w_read_hit        = 1'b0;
      w_write_hit       = 1'b0;
      w_wb_done         = 1'b0;
      w_fill            = 1'b0;
      bus.busywait      = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_address   = '0;
      bus.mem_writedata = '0;
      bus.readdata      = 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_readdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_read_hit)  r_readdata       <= w_rd_byte;
      if (w_write_hit) r_dirty[w_index] <= 1'b1;
      if (w_wb_done)   r_dirty[w_index] <= 1'b0;
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= bus.mem_readdata;
      r_tag[w_index]  <= w_tag;
    end
    if (w_write_hit) r_data[w_index][{w_offset, 3'b000} +: 8] <= bus.writedata;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  logic        w_miss_start;

  assign w_miss_start = (r_state == S_IDLE) && w_req && !w_hit && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if ((w_read_hit || w_write_hit) && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_start && (r_miss_cnt != 32'hFFFF_FFFF))              r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_done && (r_wb_cnt != 32'hFFFF_FFFF))                   r_wb_cnt   <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_count       = r_hit_cnt;
  assign miss_count      = r_miss_cnt;
  assign writeback_count = r_wb_cnt;
`endif
endmodule
